// File: rtl/mem_store_buffer.sv
// Posted-write store buffer between the datapath and the data cache port.
// Define STORE_FWD_EN to let loads forward data from matching buffered stores.
module mem_store_buffer #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                         CLK,
  input  logic                         nRST,
  input  logic                         dreq_ren,
  input  logic                         dreq_wen,
  input  logic [ADDR_W-1:0]            dreq_addr,
  input  logic [DATA_W-1:0]            dreq_wdat,
  output logic                         dreq_hit,
  output logic [DATA_W-1:0]            dreq_rdat,
  output logic                         dmemREN,
  output logic                         dmemWEN,
  output logic [ADDR_W-1:0]            dmemaddr,
  output logic [DATA_W-1:0]            dmemstore,
  input  logic [DATA_W-1:0]            dmemload,
  input  logic                         dhit,
  input  logic                         flush_req,
  output logic                         flush_done,
  output logic [$clog2(DEPTH+1)-1:0]   sb_count
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  typedef enum logic [1:0] {StIdle, StDrain, StLoad} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PW-1:0]     head_q, tail_q;
  logic [CW-1:0]     count_q;

  logic              push, pop, load_go, load_done, fwd_ok;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;

  // Fullness is judged on the registered count, so a same-cycle pop never frees a slot early.
  assign push      = dreq_wen && !flush_req && (count_q < CW'(DEPTH));
  assign pop       = (state_q == StDrain) && dhit;
  assign load_done = (state_q == StLoad) && dhit;

`ifdef STORE_FWD_EN
  // Scan oldest to youngest so the last match (youngest store) wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if ((CW'(i) < count_q) &&
          (addr_q[head_q + PW'(i)][ADDR_W-1:2] == dreq_addr[ADDR_W-1:2])) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[head_q + PW'(i)];
      end
    end
  end
  assign load_go = dreq_ren && !flush_req && !fwd_hit;
`else
  assign fwd_hit  = 1'b0;
  assign fwd_data = '0;
  assign load_go  = dreq_ren && !flush_req && (count_q == '0);
`endif

  assign fwd_ok = dreq_ren && !flush_req && fwd_hit && (state_q != StLoad);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (load_go)              state_q <= StLoad;
          else if (count_q != '0)   state_q <= StDrain;
        end
        StDrain: if (dhit) state_q <= StIdle;
        StLoad:  if (dhit) state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) tail_q <= tail_q + PW'(1);
      if (pop)  head_q <= head_q + PW'(1);
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (pop && !push) count_q <= count_q - CW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      addr_q[tail_q] <= dreq_addr;
      data_q[tail_q] <= dreq_wdat;
    end
  end

  assign dmemWEN = (state_q == StDrain);
  assign dmemREN = (state_q == StLoad);

  always_comb begin
    dmemaddr  = '0;
    dmemstore = '0;
    if (state_q == StDrain) begin
      dmemaddr  = addr_q[head_q];
      dmemstore = data_q[head_q];
    end else if (state_q == StLoad) begin
      dmemaddr  = dreq_addr;
    end
  end

  assign dreq_hit   = push || load_done || fwd_ok;
  assign dreq_rdat  = load_done ? dmemload : (fwd_ok ? fwd_data : '0);
  assign flush_done = (count_q == '0) && (state_q == StIdle);
  assign sb_count   = count_q;

endmodule

// File: tb/tb_mem_store_buffer.sv
// Directed bench for mem_store_buffer with a queue scoreboard of posted stores.
module tb_mem_store_buffer;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned CW     = $clog2(DEPTH+1);

  logic              CLK = 1'b0;
  logic              nRST = 1'b1;
  logic              dreq_ren = 1'b0, dreq_wen = 1'b0;
  logic [ADDR_W-1:0] dreq_addr = '0;
  logic [DATA_W-1:0] dreq_wdat = '0;
  logic              dreq_hit;
  logic [DATA_W-1:0] dreq_rdat;
  logic              dmemREN, dmemWEN;
  logic [ADDR_W-1:0] dmemaddr;
  logic [DATA_W-1:0] dmemstore;
  logic [DATA_W-1:0] dmemload = '0;
  logic              dhit = 1'b0;
  logic              flush_req = 1'b0;
  logic              flush_done;
  logic [CW-1:0]     sb_count;

  mem_store_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .nRST(nRST),
    .dreq_ren(dreq_ren), .dreq_wen(dreq_wen), .dreq_addr(dreq_addr), .dreq_wdat(dreq_wdat),
    .dreq_hit(dreq_hit), .dreq_rdat(dreq_rdat),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .dmemload(dmemload), .dhit(dhit),
    .flush_req(flush_req), .flush_done(flush_done), .sb_count(sb_count)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;
  logic [63:0] sb_q [$];  // {addr, data} of accepted stores, oldest first

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare the head drain beat against the scoreboard.
  task automatic chk_drain_beat();
    logic [63:0] e;
    if (sb_q.size() == 0) begin
      chk("drain_extra", dmemWEN, 1'b0);
    end else begin
      e = sb_q.pop_front();
      chk("drain_addr", dmemaddr, e[63:32]);
      chk("drain_data", dmemstore, e[31:0]);
      chk("drain_no_ren", dmemREN, 1'b0);
    end
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic exp_hit);
    @(negedge CLK);
    dreq_wen = 1'b1; dreq_ren = 1'b0; dreq_addr = a; dreq_wdat = d;
    #1;
    chk("store_hit", dreq_hit, exp_hit);
    if (exp_hit) sb_q.push_back({a, d});
  endtask

  task automatic drain_all();
    bit done = 1'b0;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge CLK);
      dreq_wen = 1'b0; dreq_ren = 1'b0; dhit = 1'b1;
      #1;
      if (dmemWEN) chk_drain_beat();
      else if (sb_q.size() == 0 && flush_done) done = 1'b1;
    end
    dhit = 1'b0;
    chk("drain_done", done, 1'b1);
    chk("drain_count", sb_count, 0);
  endtask

  initial begin
    logic [63:0] e;
    bit          fin;
    int          pops;

    // Reset
    #1 nRST = 1'b0;
    #1;
    chk("rst_hit", dreq_hit, 1'b0);
    chk("rst_wen", dmemWEN, 1'b0);
    chk("rst_ren", dmemREN, 1'b0);
    chk("rst_flush_done", flush_done, 1'b1);
    chk("rst_count", sb_count, 0);
    @(negedge CLK) nRST = 1'b1;

    // Fill with dhit low, fifth store stalls until a pop, admitted the cycle after
    for (int i = 0; i < 4; i++) do_store(32'h10 + 32'(4 * i), 32'hD000 + 32'(i), 1'b1);
    do_store(32'h20, 32'hD004, 1'b0);
    chk("full_count", sb_count, 4);
    chk("full_wen", dmemWEN, 1'b1);
    chk("full_head", dmemaddr, 32'h10);
    @(negedge CLK);
    dhit = 1'b1;
    #1;
    chk("stall_on_pop", dreq_hit, 1'b0);
    chk_drain_beat();
    @(negedge CLK);
    dhit = 1'b0;
    #1;
    chk("admit_after_pop", dreq_hit, 1'b1);
    chk("count_at_admit", sb_count, 3);
    sb_q.push_back({32'h20, 32'hD004});
    drain_all();

    // Pointer wrap: two full fill/drain rounds
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++)
        do_store(32'h100 * 32'(r + 1) + 32'(4 * i), 32'hE000 + 32'(16 * r + i), 1'b1);
      @(negedge CLK);
      dreq_wen = 1'b0;
      #1;
      chk("wrap_full", sb_count, 4);
      drain_all();
    end

    // Push and pop in the same cycle
    do_store(32'h300, 32'hF000, 1'b1);
    do_store(32'h304, 32'hF001, 1'b1);
    @(negedge CLK);
    dreq_wen = 1'b1; dreq_addr = 32'h308; dreq_wdat = 32'hF002; dhit = 1'b1;
    #1;
    chk("pushpop_hit", dreq_hit, 1'b1);
    chk_drain_beat();
    sb_q.push_back({32'h308, 32'hF002});
    @(negedge CLK);
    dreq_wen = 1'b0; dhit = 1'b0;
    #1;
    chk("pushpop_count", sb_count, 2);
    drain_all();

`ifdef STORE_FWD_EN
    // Youngest matching store forwards with no cache access
    do_store(32'h40, 32'hAAAA, 1'b1);
    do_store(32'h40, 32'hBBBB, 1'b1);
    @(negedge CLK);
    dreq_wen = 1'b0; dreq_ren = 1'b1; dreq_addr = 32'h40;
    #1;
    chk("fwd_hit", dreq_hit, 1'b1);
    chk("fwd_rdat", dreq_rdat, 32'hBBBB);
    chk("fwd_no_ren", dmemREN, 1'b0);
    drain_all();
`else
    // Load waits until the buffer has fully drained
    do_store(32'h400, 32'h1111, 1'b1);
    do_store(32'h404, 32'h2222, 1'b1);
    fin = 1'b0;
    for (int n = 0; n < 20 && !fin; n++) begin
      @(negedge CLK);
      dreq_wen = 1'b0; dreq_ren = 1'b1; dreq_addr = 32'h80;
      dmemload = 32'h1234_5678; dhit = 1'b1;
      #1;
      if (dmemWEN) chk_drain_beat();
      if (dmemREN) begin
        chk("load_after_drain", sb_count, 0);
        chk("load_addr", dmemaddr, 32'h80);
        chk("load_hit", dreq_hit, 1'b1);
        chk("load_rdat", dreq_rdat, 32'h1234_5678);
        fin = 1'b1;
      end else begin
        chk("load_wait_hit", dreq_hit, 1'b0);
        chk("load_wait_rdat", dreq_rdat, 0);
      end
    end
    chk("load_done", fin, 1'b1);
    @(negedge CLK);
    dreq_ren = 1'b0; dhit = 1'b0;
`endif

    // Flush with three entries: new store stalls, flush_done follows the third pop
    for (int i = 0; i < 3; i++) do_store(32'h500 + 32'(4 * i), 32'h5000 + 32'(i), 1'b1);
    @(negedge CLK);
    flush_req = 1'b1; dreq_wen = 1'b1; dreq_addr = 32'h600; dreq_wdat = 32'h6000;
    #1;
    chk("flush_stall", dreq_hit, 1'b0);
    chk("flush_busy", flush_done, 1'b0);
    pops = 0;
    fin  = 1'b0;
    for (int n = 0; n < 20 && !fin; n++) begin
      @(negedge CLK);
      dhit = 1'b1;
      #1;
      chk("flush_stall_loop", dreq_hit, 1'b0);
      chk("flush_done_timing", flush_done, (pops == 3));
      if (flush_done) fin = 1'b1;
      if (dmemWEN) begin
        chk_drain_beat();
        pops++;
      end
    end
    chk("flush_done_seen", fin, 1'b1);
    @(negedge CLK);
    flush_req = 1'b0; dreq_wen = 1'b0; dhit = 1'b0;

    // Asynchronous reset in the middle of a drain discards the buffer
    do_store(32'h700, 32'h7000, 1'b1);
    do_store(32'h704, 32'h7001, 1'b1);
    @(negedge CLK);
    dreq_wen = 1'b0;
    #1;
    chk("pre_rst_wen", dmemWEN, 1'b1);
    #2 nRST = 1'b0;
    #1;
    chk("midrst_wen", dmemWEN, 1'b0);
    chk("midrst_count", sb_count, 0);
    chk("midrst_flush_done", flush_done, 1'b1);
    chk("midrst_hit", dreq_hit, 1'b0);
    sb_q.delete();
    @(negedge CLK) nRST = 1'b1;
    do_store(32'h800, 32'h8000, 1'b1);
    drain_all();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_store_buffer.md
MEM_STORE_BUFFER -- requirements
Module: mem_store_buffer

Interface
REQ-001 Parameters SHALL be, one per line:
 - DATA_W, 32, data word width
 - ADDR_W, 32, byte address width
 - DEPTH, 4, store-buffer entries (power of two, >=2)
REQ-002 Ports SHALL be, one per line:
 - CLK, in, 1, the one clock; all state changes on rising edge
 - nRST, in, 1, reset, asynchronous and active-low
 - dreq_ren, in, 1, datapath load request
 - dreq_wen, in, 1, datapath store request (never asserted together with dreq_ren)
 - dreq_addr, in, ADDR_W, request address
 - dreq_wdat, in, DATA_W, store data
 - dreq_hit, out, 1, request completed this cycle
 - dreq_rdat, out, DATA_W, load data, valid when dreq_hit with dreq_ren
 - dmemREN, out, 1, cache read strobe
 - dmemWEN, out, 1, cache write strobe
 - dmemaddr, out, ADDR_W, cache address
 - dmemstore, out, DATA_W, cache write data
 - dmemload, in, DATA_W, cache read data
 - dhit, in, 1, cache transaction done
 - flush_req, in, 1, drain buffer and block new requests (halt)
 - flush_done, out, 1, buffer empty and cache port idle
 - sb_count, out, clog2(DEPTH+1), occupied entries

Function
REQ-003 Circular FIFO of DEPTH {addr,data} entries; head/tail pointers wrap modulo DEPTH; sb_count SHALL equal occupancy.
REQ-004 Store with sb_count<DEPTH at cycle start and flush_req low SHALL push at tail and assert dreq_hit combinationally that cycle (posted write).
REQ-005 Store with sb_count==DEPTH SHALL stall (dreq_hit low); a pop that same cycle SHALL NOT admit the push until the next cycle.
REQ-006 Cache-port FSM states: IDLE, DRAIN, LOAD.
REQ-007 IDLE: eligible load pending -> LOAD; else buffer non-empty -> DRAIN; else stay. Loads take priority over drain.
REQ-008 DRAIN: dmemWEN=1, dmemaddr/dmemstore = head entry, held stable until dhit; on dhit pop head, return to IDLE.
REQ-009 LOAD: dmemREN=1, dmemaddr=dreq_addr until dhit; on dhit assert dreq_hit, dreq_rdat=dmemload, return to IDLE.
REQ-010 dmemREN and dmemWEN SHALL never be high together; both low in IDLE.
REQ-011 Address match SHALL compare dreq_addr[ADDR_W-1:2] against all valid entries.
REQ-012 Push and pop in the same cycle SHALL leave sb_count unchanged and move both pointers.
REQ-013 flush_req high: new loads/stores stall; buffer keeps draining; flush_done=1 iff sb_count==0 and FSM in IDLE.
REQ-014 dreq_rdat SHALL be 0 whenever dreq_hit is low.

Reset
REQ-015 nRST low SHALL immediately force FSM to IDLE, pointers and sb_count to 0, dmemREN=dmemWEN=0, dreq_hit=0, flush_done=1; buffered stores are discarded, including reset mid-DRAIN or mid-LOAD.

Configuration
REQ-016 Macro STORE_FWD_EN defined: a load matching any entry SHALL complete in the same cycle with dreq_hit=1 and data of the youngest matching entry, with no cache access; a non-matching load is eligible immediately and bypasses older stores.
REQ-017 STORE_FWD_EN undefined: a load is eligible only when sb_count==0; no forwarding logic is instantiated.

Verification
REQ-018 Reset, then 4 stores (A=0x10..0x1C) with dhit held low -> four same-cycle dreq_hit, sb_count=4; fifth store stalls until first dhit, then is accepted next cycle.
REQ-019 FWD on: store 0x40<-0xAAAA, store 0x40<-0xBBBB, load 0x40 -> dreq_hit same cycle, dreq_rdat=0xBBBB, dmemREN never asserted.
REQ-020 FWD off: 2 stores buffered, load 0x80 -> dmemREN only after both drains complete; dreq_rdat=dmemload.
REQ-021 Buffer full (DEPTH=4), 4 pops with pointer wrap, then 4 more pushes -> drain order and addresses match issue order exactly.
REQ-022 flush_req with 3 entries -> new store stalls, flush_done rises the cycle after the third dhit.
REQ-023 nRST pulsed low mid-DRAIN with dmemWEN high -> dmemWEN drops asynchronously, sb_count=0, flush_done=1.
